// File: rtl/pkt_dma.sv
// pkt_dma: per-PU word memory with a flit-based packet DMA engine.
// The send engine streams a block of local words as HEAD/BODY.../TAIL flits.
// The receive engine writes incoming BODY flits starting at the base address
// carried in the HEAD flit.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   ad, wd, we, rd           core port; rd is a combinational read of mem[ad]
//   send, send_addr, send_raddr, send_len, send_port
//                            send request with local base, remote base,
//                            length in words and destination port
//   send_ready, send_done    engine idle / one-cycle completion pulse
//   rx, tx                   incoming / outgoing flit {type[1:0], payload}
//   rx_done, rx_err          one-cycle receive completion / protocol error
module pkt_dma #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned PORT_W = 2,
    parameter int unsigned PU_ID  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH)-1:0]   ad,
    input  logic [DATA_W-1:0]          wd,
    input  logic                       we,
    output logic [DATA_W-1:0]          rd,
    input  logic                       send,
    input  logic [$clog2(DEPTH)-1:0]   send_addr,
    input  logic [$clog2(DEPTH)-1:0]   send_raddr,
    input  logic [$clog2(DEPTH):0]     send_len,
    input  logic [PORT_W-1:0]          send_port,
    output logic                       send_ready,
    output logic                       send_done,
    input  logic [FLIT_W+1:0]          rx,
    output logic [FLIT_W+1:0]          tx,
    output logic                       rx_done,
    output logic                       rx_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned RATIO = DATA_W / FLIT_W;
    localparam int unsigned SLW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned CW    = AW + SLW + 1;
    localparam int unsigned FTW   = FLIT_W + 2;

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_PKT  = 1'b1;

    // Storage (not reset)
    logic [DATA_W-1:0] mem [DEPTH];

    assign rd = mem[ad];

    // Send engine state
    logic [0:0]        s_state_q, s_state_d;
    logic [AW-1:0]     s_word_q, s_word_d;
    logic [SLW-1:0]    s_slice_q, s_slice_d;
    logic [CW-1:0]     s_cnt_q, s_cnt_d;
    logic [FTW-1:0]    tx_q, tx_d;
    logic              send_done_q, send_done_d;
    logic [DATA_W-1:0] s_word_data;
    logic [FLIT_W-1:0] s_slice_data;

    // Receive engine state
    logic [0:0]        r_state_q, r_state_d;
    logic [AW-1:0]     r_word_q, r_word_d;
    logic [SLW-1:0]    r_slice_q, r_slice_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_err_q, rx_err_d;
    logic              rx_wr_c;
    logic [1:0]        rx_type;
    logic [FLIT_W-1:0] rx_pl;
    logic [DATA_W-1:0] wr_merge;

    assign tx         = tx_q;
    assign send_done  = send_done_q;
    assign rx_done    = rx_done_q;
    assign rx_err     = rx_err_q;
    assign send_ready = (s_state_q == S_IDLE);

    assign rx_type = rx[FTW-1:FLIT_W];
    assign rx_pl   = rx[FLIT_W-1:0];

    // Live read of the slice the send pointer addresses
    always_comb begin
        s_word_data  = mem[s_word_q];
        s_slice_data = '0;
        for (int unsigned s = 0; s < RATIO; s++) begin
            if (s_slice_q == SLW'(s)) begin
                s_slice_data = s_word_data[s*FLIT_W +: FLIT_W];
            end
        end
    end

    // Send FSM: next state and next flit
    always_comb begin
        s_state_d   = s_state_q;
        s_word_d    = s_word_q;
        s_slice_d   = s_slice_q;
        s_cnt_d     = s_cnt_q;
        tx_d        = '0;
        send_done_d = 1'b0;
        case (s_state_q)
            S_IDLE: begin
                if (send) begin
                    s_word_d  = send_addr;
                    s_slice_d = '0;
                    s_cnt_d   = CW'(send_len) * CW'(RATIO);
                    tx_d      = {FT_HEAD, FLIT_W'({send_port, send_raddr})};
                    s_state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (s_cnt_q != '0) begin
                    tx_d    = {FT_BODY, s_slice_data};
                    s_cnt_d = s_cnt_q - CW'(1);
                    if (s_slice_q == SLW'(RATIO - 1)) begin
                        s_slice_d = '0;
                        s_word_d  = s_word_q + AW'(1);
                    end else begin
                        s_slice_d = s_slice_q + SLW'(1);
                    end
                end else begin
                    tx_d        = {FT_TAIL, {FLIT_W{1'b0}}};
                    send_done_d = 1'b1;
                    s_state_d   = S_IDLE;
                end
            end
            default: s_state_d = S_IDLE;
        endcase
    end

    // Send FSM registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state_q   <= S_IDLE;
            s_word_q    <= '0;
            s_slice_q   <= '0;
            s_cnt_q     <= '0;
            tx_q        <= '0;
            send_done_q <= 1'b0;
        end else begin
            s_state_q   <= s_state_d;
            s_word_q    <= s_word_d;
            s_slice_q   <= s_slice_d;
            s_cnt_q     <= s_cnt_d;
            tx_q        <= tx_d;
            send_done_q <= send_done_d;
`ifndef SYNTHESIS
            if (send && (s_state_q != S_IDLE)) begin
                $display("pkt_dma[%0d]: send request ignored, engine busy", PU_ID);
            end
`endif
        end
    end

    // Receive FSM: pointer tracking, write strobe and status pulses
    always_comb begin
        r_state_d = r_state_q;
        r_word_d  = r_word_q;
        r_slice_d = r_slice_q;
        rx_done_d = 1'b0;
        rx_err_d  = 1'b0;
        rx_wr_c   = 1'b0;
        case (rx_type)
            FT_IDLE: begin
            end
            FT_HEAD: begin
                // A HEAD inside a packet abandons the previous one
                r_word_d  = rx_pl[AW-1:0];
                r_slice_d = '0;
                r_state_d = R_PKT;
                rx_err_d  = (r_state_q == R_PKT);
            end
            FT_BODY: begin
                if (r_state_q == R_PKT) begin
                    rx_wr_c = 1'b1;
                    if (r_slice_q == SLW'(RATIO - 1)) begin
                        r_slice_d = '0;
                        r_word_d  = r_word_q + AW'(1);
                    end else begin
                        r_slice_d = r_slice_q + SLW'(1);
                    end
                end else begin
                    rx_err_d = 1'b1;
                end
            end
            FT_TAIL: begin
                if (r_state_q == R_PKT) begin
                    r_state_d = R_IDLE;
                    // A packet ending mid-word is an error; written slices stay
                    if (r_slice_q == '0) begin
                        rx_done_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    rx_err_d = 1'b1;
                end
            end
        endcase
    end

    // Receive FSM registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_word_q  <= '0;
            r_slice_q <= '0;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_word_q  <= r_word_d;
            r_slice_q <= r_slice_d;
            rx_done_q <= rx_done_d;
            rx_err_q  <= rx_err_d;
        end
    end

    // Received slice overlaid on the word; a same-word core write supplies
    // the other slices
    always_comb begin
        wr_merge = (we && (ad == r_word_q)) ? wd : mem[r_word_q];
        for (int unsigned s = 0; s < RATIO; s++) begin
            if (r_slice_q == SLW'(s)) begin
                wr_merge[s*FLIT_W +: FLIT_W] = rx_pl;
            end
        end
    end

    // Memory write port: receive write first, core write when not colliding
    always_ff @(posedge clk) begin
        if (rx_wr_c) begin
            mem[r_word_q] <= wr_merge;
        end
        if (we && !(rx_wr_c && (ad == r_word_q))) begin
            mem[ad] <= wd;
        end
    end

endmodule

// File: tb/tb_pkt_dma.sv
// Self-checking bench for pkt_dma (DATA_W=32, FLIT_W=16, DEPTH=256, PORT_W=2).
module tb_pkt_dma;

    logic        clk;
    logic        rst;
    logic [7:0]  ad;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        send;
    logic [7:0]  send_addr;
    logic [7:0]  send_raddr;
    logic [8:0]  send_len;
    logic [1:0]  send_port;
    logic        send_ready;
    logic        send_done;
    logic [17:0] rx;
    logic [17:0] tx;
    logic        rx_done;
    logic        rx_err;

    pkt_dma #(.DATA_W(32), .FLIT_W(16), .DEPTH(256), .PORT_W(2), .PU_ID(0)) dut (
        .clk(clk), .rst(rst), .ad(ad), .wd(wd), .we(we), .rd(rd),
        .send(send), .send_addr(send_addr), .send_raddr(send_raddr),
        .send_len(send_len), .send_port(send_port), .send_ready(send_ready),
        .send_done(send_done), .rx(rx), .tx(tx), .rx_done(rx_done), .rx_err(rx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] model_mem [256];
    logic [17:0] got[$];
    logic [17:0] exp[$];
    int rdy_low, done_cnt, done_at_tail, rxd_cnt, rxe_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input int a, input logic [31:0] d);
        ad = 8'(a); wd = d; we = 1'b1;
        tick();
        we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic read_mem(input int a, output logic [31:0] d);
        ad = 8'(a);
        #1;
        d = rd;
    endtask

    task automatic scan_mem(output int bad, output int fa, output logic [31:0] fg, output logic [31:0] fw);
        logic [31:0] d;
        bad = 0; fa = 0; fg = '0; fw = '0;
        for (int a = 0; a < 256; a++) begin
            read_mem(a, d);
            if (d !== model_mem[a]) begin
                if (bad == 0) begin fa = a; fg = d; fw = model_mem[a]; end
                bad++;
            end
        end
    endtask

    // Reference flit stream of one packet, appended to exp
    task automatic build_exp(input int a, input int ra, input int p, input int len);
        logic [31:0] w;
        exp.push_back({2'b01, 6'b000000, 2'(p), 8'(ra)});
        for (int i = 0; i < len; i++) begin
            w = model_mem[(a + i) % 256];
            exp.push_back({2'b10, w[15:0]});
            exp.push_back({2'b10, w[31:16]});
        end
        exp.push_back({2'b11, 16'h0000});
    endtask

    task automatic model_copy(input int a, input int ra, input int len);
        for (int i = 0; i < len; i++) model_mem[(ra + i) % 256] = model_mem[(a + i) % 256];
    endtask

    task automatic sample_run();
        got.push_back(tx);
        if (!send_ready) rdy_low++;
        if (send_done) done_cnt++;
        if (tx[17:16] == 2'b11 && send_done) done_at_tail = 1;
        rxd_cnt += int'(rx_done);
        rxe_cnt += int'(rx_err);
    endtask

    // Issue one send and record the flit stream; loop=1 feeds tx back into rx
    task automatic run_send(input int a, input int ra, input int p, input int len, input bit loop);
        int budget;
        got.delete();
        rdy_low = 0; done_cnt = 0; done_at_tail = 0; rxd_cnt = 0; rxe_cnt = 0;
        send_addr = 8'(a); send_raddr = 8'(ra); send_port = 2'(p); send_len = 9'(len);
        send = 1'b1;
        tick();
        send = 1'b0;
        sample_run();
        budget = 2 * len + 8;
        while (tx[17:16] != 2'b11 && budget > 0) begin
            if (loop) rx = tx;
            tick();
            sample_run();
            budget--;
        end
        if (loop) begin
            rx = tx;
            tick();
            rxd_cnt += int'(rx_done); rxe_cnt += int'(rx_err); done_cnt += int'(send_done);
            rx = '0;
            tick();
            rxd_cnt += int'(rx_done); rxe_cnt += int'(rx_err); done_cnt += int'(send_done);
        end
    endtask

    task automatic rx_flit(input logic [1:0] t, input logic [15:0] p, output logic e, output logic d);
        rx = {t, p};
        tick();
        e = rx_err;
        d = rx_done;
        rx = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_cmp++; if (tx !== 18'h0) begin n_fail++; $display("FAIL reset_tx: got %h want 0", tx); end
        n_cmp++; if (send_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", send_ready); end
        n_cmp++; if (send_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", send_done); end
        n_cmp++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
        n_cmp++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
        rst = 1'b1;
        tick();
        for (int a = 0; a < 256; a++) core_write(a, $urandom);
    endtask

    task automatic test_basic_send();
        logic [17:0] lit [6];
        lit = '{18'h10210, 18'h2CCDD, 18'h2AABB, 18'h23344, 18'h21122, 18'h30000};
        core_write(4, 32'hAABBCCDD);
        core_write(5, 32'h11223344);
        run_send(4, 8'h10, 2, 2, 1'b0);
        n_cmp++; if (got.size() !== 6) begin n_fail++; $display("FAIL basic_len: got %0d flits want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== lit[i]) begin n_fail++; $display("FAIL basic_flit%0d: got %h want %h", i, got[i], lit[i]); end
        end
        n_cmp++; if (rdy_low !== 5) begin n_fail++; $display("FAIL basic_ready_low: got %0d cycles want 5", rdy_low); end
        n_cmp++; if (done_at_tail !== 1 || done_cnt !== 1) begin
            n_fail++; $display("FAIL basic_done: got at_tail=%0d count=%0d want 1/1", done_at_tail, done_cnt); end
        tick();
        n_cmp++; if (tx !== 18'h0) begin n_fail++; $display("FAIL basic_idle_after: got %h want 0", tx); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        run_send(4, 8'h10, 2, 2, 1'b1);
        model_copy(4, 8'h10, 2);
        read_mem(8'h10, d);
        n_cmp++; if (d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL loop_mem10: got %h want aabbccdd", d); end
        read_mem(8'h11, d);
        n_cmp++; if (d !== 32'h11223344) begin n_fail++; $display("FAIL loop_mem11: got %h want 11223344", d); end
        n_cmp++; if (rxd_cnt !== 1) begin n_fail++; $display("FAIL loop_rx_done: got %0d pulses want 1", rxd_cnt); end
        n_cmp++; if (rxe_cnt !== 0) begin n_fail++; $display("FAIL loop_rx_err: got %0d pulses want 0", rxe_cnt); end
    endtask

    task automatic test_len0();
        exp.delete();
        build_exp(9, 8'h33, 1, 0);
        run_send(9, 8'h33, 1, 0, 1'b0);
        n_cmp++; if (got.size() !== 2) begin n_fail++; $display("FAIL len0_len: got %0d flits want 2", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL len0_flit%0d: got %h want %h", i, got[i], exp[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit second;
        int budget;
        exp.delete();
        build_exp(8'h28, 8'h31, 2, 1);
        build_exp(8'h2A, 8'h32, 1, 2);
        got.delete(); second = 0; budget = 40;
        send_addr = 8'h28; send_raddr = 8'h31; send_port = 2'd2; send_len = 9'd1;
        send = 1'b1;
        tick();
        send = 1'b0;
        got.push_back(tx);
        while (budget > 0 && !(second && tx[17:16] == 2'b11)) begin
            if (!second && tx[17:16] == 2'b11) begin
                send_addr = 8'h2A; send_raddr = 8'h32; send_port = 2'd1; send_len = 9'd2;
                send = 1'b1;
                second = 1;
            end
            tick();
            send = 1'b0;
            got.push_back(tx);
            budget--;
        end
        n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL b2b_len: got %0d flits want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_flit%0d: got %h want %h", i, got[i], exp[i]); end
        end
        tick();
    endtask

    task automatic test_ignored_send();
        int budget;
        exp.delete();
        build_exp(8'h20, 8'h30, 1, 3);
        exp.push_back(18'h0);
        exp.push_back(18'h0);
        got.delete();
        send_addr = 8'h20; send_raddr = 8'h30; send_port = 2'd1; send_len = 9'd3;
        send = 1'b1;
        tick();
        send = 1'b0;
        got.push_back(tx);
        tick();
        got.push_back(tx);
        send_addr = 8'h50; send_raddr = 8'h07; send_port = 2'd3; send_len = 9'd1;
        send = 1'b1;
        tick();
        send = 1'b0;
        got.push_back(tx);
        budget = 20;
        while (tx[17:16] != 2'b11 && budget > 0) begin
            tick();
            got.push_back(tx);
            budget--;
        end
        tick(); got.push_back(tx);
        tick(); got.push_back(tx);
        n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL ign_len: got %0d flits want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL ign_flit%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] va, vb, d;
        va = $urandom; vb = $urandom;
        core_write(255, va);
        core_write(0, vb);
        exp.delete();
        build_exp(255, 8'h40, 0, 2);
        run_send(255, 8'h40, 0, 2, 1'b1);
        model_copy(255, 8'h40, 2);
        n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL wrap_tx_len: got %0d flits want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_tx_flit%0d: got %h want %h", i, got[i], exp[i]); end
        end
        core_write(255, ~va);
        core_write(0, ~vb);
        run_send(8'h40, 255, 1, 2, 1'b1);
        model_copy(8'h40, 255, 2);
        read_mem(255, d);
        n_cmp++; if (d !== va) begin n_fail++; $display("FAIL wrap_rx_top: got %h want %h", d, va); end
        read_mem(0, d);
        n_cmp++; if (d !== vb) begin n_fail++; $display("FAIL wrap_rx_zero: got %h want %h", d, vb); end
        n_cmp++; if (rxd_cnt !== 1) begin n_fail++; $display("FAIL wrap_rx_done: got %0d pulses want 1", rxd_cnt); end
    endtask

    task automatic test_errors();
        logic e, d, e_hd, d_sum;
        logic [15:0] p0, p1, p2;
        int bad, fa;
        logic [31:0] fg, fw;
        rx_flit(2'b10, 16'hBEEF, e, d);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_body_idle: got rx_err=%b want 1", e); end
        scan_mem(bad, fa, fg, fw);
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL err_body_mem: got %0d bad words (first %0d = %h, want %h)", bad, fa, fg, fw); end

        p0 = 16'($urandom); p1 = 16'($urandom); p2 = 16'($urandom);
        d_sum = 1'b0; e_hd = 1'b0;
        rx_flit(2'b01, 16'h0060, e, d); e_hd |= e; d_sum |= d;
        rx_flit(2'b10, p0, e, d); e_hd |= e; d_sum |= d;
        rx_flit(2'b10, p1, e, d); e_hd |= e; d_sum |= d;
        rx_flit(2'b10, p2, e, d); e_hd |= e; d_sum |= d;
        rx_flit(2'b11, 16'h0000, e, d); d_sum |= d;
        n_cmp++; if (e !== 1'b1 || e_hd !== 1'b0) begin n_fail++; $display("FAIL err_partial: got tail_err=%b early_err=%b want 1/0", e, e_hd); end
        n_cmp++; if (d_sum !== 1'b0) begin n_fail++; $display("FAIL err_partial_done: got %b want 0", d_sum); end
        model_mem[8'h60] = {p1, p0};
        model_mem[8'h61][15:0] = p2;

        p0 = 16'($urandom); p1 = 16'($urandom); p2 = 16'($urandom);
        rx_flit(2'b01, 16'h0070, e, d);
        rx_flit(2'b10, p0, e, d);
        rx_flit(2'b01, 16'h0278, e_hd, d);
        rx_flit(2'b10, p1, e, d);
        rx_flit(2'b10, p2, e, d);
        rx_flit(2'b11, 16'h0000, e, d);
        n_cmp++; if (e_hd !== 1'b1) begin n_fail++; $display("FAIL err_head_mid: got rx_err=%b want 1", e_hd); end
        n_cmp++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL err_head_tail: got done=%b err=%b want 1/0", d, e); end
        model_mem[8'h70][15:0] = p0;
        model_mem[8'h78] = {p2, p1};

        rx_flit(2'b11, 16'h0000, e, d);
        n_cmp++; if (e !== 1'b1 || d !== 1'b0) begin n_fail++; $display("FAIL err_tail_idle: got err=%b done=%b want 1/0", e, d); end
        scan_mem(bad, fa, fg, fw);
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL err_mem: got %0d bad words (first %0d = %h, want %h)", bad, fa, fg, fw); end
    endtask

    task automatic test_collision();
        logic e, d;
        logic [31:0] r, v;
        logic [15:0] p0, p1;
        rx_flit(2'b01, 16'h0090, e, d);
        ad = 8'h90; wd = 32'hFFFFFFFF; we = 1'b1;
        rx_flit(2'b10, 16'h1234, e, d);
        we = 1'b0;
        rx_flit(2'b11, 16'h0000, e, d);
        model_mem[8'h90] = 32'hFFFF1234;
        read_mem(8'h90, v);
        n_cmp++; if (v !== 32'hFFFF1234) begin n_fail++; $display("FAIL coll_slice0: got %h want ffff1234", v); end

        r = $urandom; p0 = 16'($urandom); p1 = 16'($urandom);
        rx_flit(2'b01, 16'h0091, e, d);
        rx_flit(2'b10, p0, e, d);
        ad = 8'h91; wd = r; we = 1'b1;
        rx_flit(2'b10, p1, e, d);
        we = 1'b0;
        rx_flit(2'b11, 16'h0000, e, d);
        n_cmp++; if (d !== 1'b1) begin n_fail++; $display("FAIL coll_done: got %b want 1", d); end
        model_mem[8'h91] = {p1, r[15:0]};
        read_mem(8'h91, v);
        n_cmp++; if (v !== model_mem[8'h91]) begin n_fail++; $display("FAIL coll_slice1: got %h want %h", v, model_mem[8'h91]); end
    endtask

    task automatic test_random();
        int a, ra, p, len, bad, fa;
        logic [31:0] fg, fw;
        for (int it = 0; it < 6; it++) begin
            a = $urandom_range(0, 8'h78);
            ra = 8'h80 + $urandom_range(0, 8'h70);
            len = $urandom_range(0, 6);
            p = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) core_write((a + i) % 256, $urandom);
            exp.delete();
            build_exp(a, ra, p, len);
            run_send(a, ra, p, len, 1'b1);
            model_copy(a, ra, len);
            n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL rnd%0d_len: got %0d flits want %0d", it, got.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd%0d_flit%0d: got %h want %h", it, i, got[i], exp[i]); end
            end
            n_cmp++; if (rxd_cnt !== 1 || rxe_cnt !== 0 || done_cnt !== 1) begin
                n_fail++; $display("FAIL rnd%0d_pulses: got rx_done=%0d rx_err=%0d send_done=%0d want 1/0/1", it, rxd_cnt, rxe_cnt, done_cnt); end
        end
        scan_mem(bad, fa, fg, fw);
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rnd_mem: got %0d bad words (first %0d = %h, want %h)", bad, fa, fg, fw); end
    endtask

    task automatic test_async_reset();
        int seen;
        send_addr = 8'h20; send_raddr = 8'h05; send_port = 2'd3; send_len = 9'd4;
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (tx !== 18'h0) begin n_fail++; $display("FAIL arst_tx: got %h want 0", tx); end
        n_cmp++; if (send_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", send_ready); end
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx !== 18'h0 || send_done !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL arst_quiet: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        rst = 1'b0; ad = '0; wd = '0; we = 1'b0; send = 1'b0;
        send_addr = '0; send_raddr = '0; send_len = '0; send_port = '0; rx = '0;
        test_reset();
        test_basic_send();
        test_loopback();
        test_len0();
        test_back_to_back();
        test_ignored_send();
        test_wrap();
        test_errors();
        test_collision();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_dma.md
Name: pkt_dma

Overview:
- Parametrised per-PU data memory with a packet DMA engine. Successor to the fixed-width dmem.
- Width, depth and flit size are generalised. The HEAD flit carries a remote base address, so the receiver no longer writes from address 0.
- Adds a send handshake (send_ready/send_done), receive completion and error reporting.
- Sits between a PU core (load/store/SEND) and its router port.

Parameters:
- DATA_W, 32, memory word width; must equal RATIO*FLIT_W with RATIO ≥ 1 an integer.
- FLIT_W, 16, flit payload width; must be ≥ PORT_W+AW.
- DEPTH, 256, words of memory, power of 2; AW = log2(DEPTH).
- PORT_W, 2, destination port field width.
- PU_ID, 0, instance id, used only in $display traces.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- ad  in  AW  core word address.
- wd  in  DATA_W  core write data.
- we  in  1  core write enable.
- rd  out  DATA_W  combinational read, mem[ad].
- send  in  1  send request.
- send_addr  in  AW  local source base word address.
- send_raddr  in  AW  remote destination base word address.
- send_len  in  AW+1  length in words, 0..DEPTH.
- send_port  in  PORT_W  destination port.
- send_ready  out  1  engine can accept send.
- send_done  out  1  one-cycle pulse.
- rx  in  FLIT_W+2  incoming flit, {type[1:0], payload}.
- tx  out  FLIT_W+2  outgoing flit.
- rx_done  out  1  one-cycle pulse at valid TAIL.
- rx_err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Flit type encoding: 00 IDLE, 01 HEAD, 10 BODY, 11 TAIL.
- HEAD payload layout: [PORT_W+AW-1:AW] = port, [AW-1:0] = remote base; all other bits 0.
- Reset (rst low, async): tx=0, send_ready=1, send_done=0, rx_done=0, rx_err=0, both FSMs in IDLE, all pointers 0. Memory contents are not reset.
- Core write: mem[ad] <= wd on clk when we=1.
- Send FSM states: S_IDLE, S_BODY.
  - send_ready = (state==S_IDLE).
  - send is ignored when send_ready=0, and a $display warning is printed.
  - S_IDLE with send=1: latch ptr={send_addr, slice 0} and cnt=send_len*RATIO; tx<=HEAD{send_port, send_raddr}; go to S_BODY. HEAD appears 1 cycle after send is sampled.
  - S_IDLE without send: tx<=0.
  - S_BODY with cnt≠0: tx<=BODY with slice s of mem[word], lowest slice first; ptr++, cnt--. Word address wraps modulo DEPTH.
  - S_BODY with cnt=0: tx<=TAIL (payload 0); send_done<=1; go to S_IDLE.
  - Total flits = 2 + len*RATIO. len=0 gives HEAD then TAIL.
  - A send sampled in the TAIL-issue cycle is accepted; its HEAD follows TAIL with no gap.
  - Memory is read live at flit emission. Core writes during a transfer are visible if they land before that word's slices are read.
- Receive FSM states: R_IDLE, R_PKT.
  - HEAD in any state: rptr={payload[AW-1:0], slice 0}; go to R_PKT. If already in R_PKT, also pulse rx_err (previous packet abandoned).
  - BODY in R_PKT: write slice rptr.slice of word rptr.word; rptr++ with wrap.
  - BODY in R_IDLE: dropped, rx_err pulse.
  - TAIL in R_PKT: go to R_IDLE. rx_done pulse if rptr.slice==0, else rx_err pulse (partial word; the slices already written are kept).
  - TAIL in R_IDLE: rx_err pulse.
  - IDLE flits: no action.
- Write collision (core we and rx BODY hit the same word in the same cycle): word = wd with the rx slice overlaid. rx wins its slice; the core wins the remaining slices.
- Send and receive are fully independent and may run concurrently.
- Reset mid-transfer: tx is 0 immediately (asynchronous). No TAIL is emitted and no done pulse is produced.

Test Plan:
- Reset, preload mem[4]=0xAABBCCDD, mem[5]=0x11223344; send addr=4, raddr=0x10, port=2, len=2. Required tx sequence: HEAD payload 0x0210, then BODY CCDD, AABB, 3344, 1122, then TAIL. send_done pulses with TAIL. send_ready is low for 5 cycles.
- Loop tx to rx with the same transfer. Required: mem[0x10]=0xAABBCCDD, mem[0x11]=0x11223344; rx_done pulses once; rx_err never pulses.
- len=0 → HEAD then TAIL. Back-to-back send asserted during TAIL → next HEAD in the following cycle. send pulsed mid-transfer → ignored, no tx change.
- Wrap: send addr=DEPTH-1, len=2 → body comes from words DEPTH-1 then 0. Receive with raddr=DEPTH-1 → writes land in words DEPTH-1 and 0.
- Errors: BODY with no HEAD → rx_err, memory unchanged. TAIL after 3 BODY flits → rx_err, no rx_done. HEAD mid-packet → rx_err, new base used.
- Collision: core writes 0xFFFFFFFF to word W while rx writes slice 0 = 0x1234 → mem[W]=0xFFFF1234. Async reset low mid-send → tx=0 with no clock edge; send_ready=1.
